combi_store_buffer: RTL and testbench

- Posted-write FIFO between the combi core's data-memory write port (MemWrite, DataAdr, WriteData) and the data memory's write port.
- Accepts stores in one cycle and retires them to memory over a req/ack handshake, so slow memory writes do not stall the core.
- Stalls the core on a full buffer, or on a load to a word that still has a pending store.
- The data memory read port is separate and is untouched by this block.

---
 rtl/combi_store_buffer_pkg.sv | 14 +
 rtl/combi_store_buffer_hit_cmp.sv | 38 +++
 rtl/combi_store_buffer.sv | 87 ++++++++
 tb/tb_combi_store_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/combi_store_buffer_pkg.sv
// Shared types and constants for the combi core posted-write store buffer.
// Entry layout is fixed by the package address/data widths.
package combi_pkg;
    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int WORD_LSB         = 2;
    localparam int SB_AW            = 32;
    localparam int SB_DW            = 32;

    typedef struct packed {
        logic [SB_AW-1:0]   adr;
        logic [SB_DW-1:0]   wdata;
        logic [SB_DW/8-1:0] be;
    } sb_entry_t;
endpackage

// File: rtl/combi_store_buffer_hit_cmp.sv
// Word-address match of a load against every pending store entry.
// Purely combinational; an entry counts only if it lies between read pointer and read pointer + count.
module sb_hit_cmp
    import combi_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW
) (
    input  sb_entry_t                  ent_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr_i,
    input  logic [$clog2(DEPTH):0]     count_i,
    input  logic [AW-1:0]              adr_i,
    output logic                       hit_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ofs;
    logic          unused_fold;

    // Distance from the head decides validity, so wrap-around needs no special case.
    always_comb begin
        hit_o = 1'b0;
        ofs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ofs = PW'(i) - rd_ptr_i;
            if (({1'b0, ofs} < count_i) &&
                (ent_i[i].adr[AW-1:WORD_LSB] == adr_i[AW-1:WORD_LSB]))
                hit_o = 1'b1;
        end
    end

    always_comb begin
        unused_fold = ^adr_i[WORD_LSB-1:0];
        for (int i = 0; i < DEPTH; i++)
            unused_fold = unused_fold ^ (^ent_i[i].wdata) ^ (^ent_i[i].be)
                        ^ (^ent_i[i].adr[WORD_LSB-1:0]);
    end
endmodule

// File: rtl/combi_store_buffer.sv
// Posted-write FIFO between the combi core store port and data memory, retired over req/ack.
// Store accepted in one cycle, visible at the head after the next edge; stalls on full or load word hit.
module combi_store_buffer
    import combi_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic [AW-1:0]   DataAdr,
    input  logic [DW-1:0]   WriteData,
    input  logic [DW/8-1:0] ByteEn,
    output logic            Stall,
    output logic            mem_req,
    output logic [AW-1:0]   mem_adr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    output logic            empty,
    output logic            full
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    sb_entry_t     ent_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          push, pop, hit;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign mem_req = !empty;
    // Full blocks the push even when the head retires this same cycle.
    assign push    = MemWrite && !full;
    assign pop     = mem_req && mem_ack;
    assign Stall   = (MemWrite && full) || (MemRead && hit);

    assign mem_adr   = ent_q[rd_q].adr;
    assign mem_wdata = ent_q[rd_q].wdata;
    assign mem_be    = ent_q[rd_q].be;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[wr_q].adr   <= DataAdr;
            ent_q[wr_q].wdata <= WriteData;
            ent_q[wr_q].be    <= ByteEn;
        end
    end

    sb_hit_cmp #(.DEPTH(DEPTH), .AW(AW)) u_hit (
        .ent_i    (ent_q),
        .rd_ptr_i (rd_q),
        .count_i  (cnt_q),
        .adr_i    (DataAdr),
        .hit_o    (hit)
    );
endmodule

// File: tb/tb_combi_store_buffer.sv
// Randomized and directed bench for combi_store_buffer with a queue reference model and scoreboard.
module tb_combi_store_buffer;
    import combi_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead, mem_ack;
    logic [31:0] DataAdr, WriteData;
    logic [3:0]  ByteEn;
    logic        Stall, mem_req, empty, full;
    logic [31:0] mem_adr, mem_wdata;
    logic [3:0]  mem_be;

    combi_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ByteEn    (ByteEn),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_t;

    st_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        foreach (exp_q[i])
            if (exp_q[i].adr[31:2] == a[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every retire handshake must deliver the oldest outstanding store.
    always @(negedge clk) begin
        st_t e;
        if (reset === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("retire_adr", mem_adr, e.adr);
                chk("retire_wdata", mem_wdata, e.wdata);
                chk("retire_be", mem_be, e.be);
            end
        end
    end

    // Called at posedge+1; drives one cycle, checks settled outputs, returns at the next posedge+1.
    task automatic cycle(input bit mw, input bit mr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit ack, output bit acc, output bit st);
        bit  exp_full, exp_stall;
        st_t e;
        MemWrite  = mw;
        MemRead   = mr;
        DataAdr   = a;
        WriteData = wd;
        ByteEn    = be;
        mem_ack   = ack;
        #1;
        exp_full  = (exp_q.size() == DEPTH);
        exp_stall = (mw && exp_full) || (mr && model_hit(a));
        st = Stall;
        chk("stall", Stall, exp_stall);
        chk("full", full, exp_full);
        chk("empty", empty, exp_q.size() == 0);
        chk("mem_req", mem_req, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("head_adr", mem_adr, exp_q[0].adr);
            chk("head_wdata", mem_wdata, exp_q[0].wdata);
            chk("head_be", mem_be, exp_q[0].be);
        end
        acc = mw && !exp_full;
        @(negedge clk);
        if (acc) begin
            e.adr = a; e.wdata = wd; e.be = be;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ack_mode: 0 low, 1 high, 2 random, 3 toggling every other cycle
    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int ack_mode);
        bit acc, st, ack;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            case (ack_mode)
                0:       ack = 1'b0;
                1:       ack = 1'b1;
                2:       ack = 1'($urandom % 2);
                default: ack = 1'(cyc % 2);
            endcase
            cycle(1'b1, 1'b0, a, wd, be, ack, acc, st);
        end
        if (!acc) chk("store_retry_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc, st;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, acc, st);
        chk("drain_empty", empty, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, st;
        bit mw, mr;
        MemWrite = 0; MemRead = 0; DataAdr = 0; WriteData = 0; ByteEn = 0; mem_ack = 0;
        reset = 1'b0;
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_full", full, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // single store with ack tied high
        cycle(1, 0, 32'd100, 32'd7, 4'hF, 1, acc, st);
        chk("t1_req", mem_req, 1'b1);
        chk("t1_adr", mem_adr, 32'd100);
        chk("t1_wdata", mem_wdata, 32'd7);
        chk("t1_be", mem_be, 4'hF);
        cycle(0, 0, 0, 0, 0, 1, acc, st);
        chk("t1_empty", empty, 1'b1);

        // fill with ack low, fifth store stalls and is retried
        for (int k = 0; k < 4; k++)
            cycle(1, 0, 32'(96 + 4*k), 32'(k + 1), 4'hF, 0, acc, st);
        chk("fill_full", full, 1'b1);
        cycle(1, 0, 32'd112, 32'd5, 4'hF, 0, acc, st);
        chk("fill_fifth_stall", st, 1'b1);
        cycle(1, 0, 32'd112, 32'd5, 4'hF, 1, acc, st);
        chk("full_pop_no_push_stall", st, 1'b1);
        store(32'd112, 32'd5, 4'hF, 1);
        drain();

        // load word hit against a pending store
        store(32'd192, 32'd25, 4'hF, 0);
        cycle(0, 1, 32'd194, 0, 0, 0, acc, st);
        chk("hit_194", st, 1'b1);
        cycle(0, 1, 32'd196, 0, 0, 0, acc, st);
        chk("miss_196", st, 1'b0);
        cycle(0, 1, 32'd194, 0, 0, 1, acc, st);
        chk("hit_while_popping", st, 1'b1);
        cycle(0, 1, 32'd194, 0, 0, 0, acc, st);
        chk("after_ack_194", st, 1'b0);

        // wrap-around with toggling ack
        for (int k = 0; k < 10; k++)
            store(32'(32'h400 + 4*k), 32'(32'hA0 + k), 4'hF, 3);
        drain();

        // sub-word store
        store(32'd97, 32'h0000AB00, 4'b0010, 0);
        chk("sb_be", mem_be, 4'b0010);
        chk("sb_adr", mem_adr, 32'd97);
        chk("sb_wdata", mem_wdata, 32'h0000AB00);
        drain();

        // asynchronous reset with two entries pending
        store(32'd300, 32'd1, 4'hF, 0);
        store(32'd304, 32'd2, 4'hF, 0);
        chk("pre_rst_req", mem_req, 1'b1);
        MemWrite = 0; MemRead = 0; mem_ack = 1;
        reset = 1'b0;
        #1;
        chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_empty", empty, 1'b1);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            mw = ($urandom % 3) == 0;
            mr = !mw && (($urandom % 3) == 0);
            cycle(mw, mr, 32'h200 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(1, 15)), 1'($urandom % 2), acc, st);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
